tt_ldb_drain_ctrl: RTL
======================

TT_LDB_DRAIN_CTRL -- requirements
Module: tt_ldb_drain_ctrl

Interface
REQ-001 SHALL have parameter: DATA_W, 512, width of one load-data-buffer (LDB) entry and of write data.
REQ-002 SHALL have ports: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have ports: reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: i_drain_valid  in  1  drain request from scoreboard.
REQ-005 SHALL have ports: i_drain_ref_count  in  3  entries to drain (0..7).
REQ-006 SHALL have ports: i_drain_lqid_start  in  3  first load-queue id.
REQ-007 SHALL have ports: i_drain_ldb_start  in  3  first LDB index.
REQ-008 SHALL have ports: o_draining  out  1  drain in progress, back to scoreboard.
REQ-009 SHALL have ports: o_ldb_rd_en  out  1  and  o_ldb_rd_idx  out  3  LDB read port; data returns next cycle.
REQ-010 SHALL have ports: i_ldb_rd_data  in  DATA_W  LDB read data.
REQ-011 SHALL have ports: o_wr_valid  out  1,  o_wr_data  out  DATA_W,  o_wr_lqid  out  3,  o_wr_last  out  1,  i_wr_ready  in  1  write-back beat to VRF writer.
REQ-012 SHALL have ports: o_drain_complete_valid  out  1  and  o_drain_complete_ldb_idx  out  3  LDB entry freed.

Function
REQ-013 SHALL implement FSM IDLE/ACTIVE; o_draining = (state==ACTIVE).
REQ-014 In IDLE with i_drain_valid=1, SHALL capture ref_count, lqid_start, ldb_start and enter ACTIVE next cycle; requests while ACTIVE SHALL be ignored.
REQ-015 SHALL keep remaining-count (3b), read pointer (3b) and lqid pointer (3b); pointers increment mod 8 (7 wraps to 0).
REQ-016 SHALL hold one pending beat register (valid, ldb_idx, lqid, last); beat advances when pending empty or i_wr_ready=1.
REQ-017 On advance with remaining>0: o_ldb_rd_en=1, o_ldb_rd_idx=read pointer, pending loads that idx/lqid, last=(remaining==1), remaining-1, pointers +1; otherwise pending clears.
REQ-018 o_wr_valid=pending valid; o_wr_data=i_ldb_rd_data; o_wr_lqid/o_wr_last from pending.
REQ-019 While pending valid and i_wr_ready=0, SHALL re-issue o_ldb_rd_en=1 at pending ldb_idx so o_wr_data stays valid; o_wr_* SHALL stay stable.
REQ-020 Beat accepted (o_wr_valid & i_wr_ready): SHALL pulse o_drain_complete_valid same cycle with pending ldb_idx.
REQ-021 SHALL return to IDLE in the cycle after the last beat is accepted (remaining==0, no pending).
REQ-022 Throughput SHALL be one beat per cycle with i_wr_ready=1; first o_wr_valid two cycles after request cycle.
REQ-023 ref_count=0: SHALL enter ACTIVE for one cycle, issue no reads/beats/completions, return to IDLE.
REQ-024 Back-to-back requests: next request accepted no earlier than first IDLE cycle after previous drain.

Reset
REQ-025 On reset_n=0: state IDLE, counters/pointers 0, pending invalid; o_draining, o_ldb_rd_en, o_wr_valid, o_wr_last, o_drain_complete_valid = 0 immediately (async).
REQ-026 Reset mid-drain SHALL discard in-flight beats without completions; no request is retained.

Configuration
REQ-027 Macro TT_LDB_DRAIN_PERF_CNT_EN SHALL, when defined, add outputs o_perf_beats (32b, accepted beats) and o_perf_stall_cycles (32b, cycles o_wr_valid & !i_wr_ready), both reset to 0, wrap at 2^32.
REQ-028 Without TT_LDB_DRAIN_PERF_CNT_EN these ports and counters SHALL not exist; other behaviour identical.

Verification
REQ-029 Request ref=3, lqid=2, ldb=5, ready=1 -> beats ldb 5,6,7 / lqid 2,3,4, last on third, completions 5,6,7 on consecutive cycles.
REQ-030 Request ref=4, ldb=6 -> read idx 6,7,0,1 (wrap), four completions, then IDLE.
REQ-031 ref=2, i_wr_ready low 3 cycles on first beat -> o_wr_* stable, rd re-issued at same idx, no completion until ready; stall counter +3 with macro.
REQ-032 ref=0 request -> o_draining high exactly one cycle, zero beats/completions.
REQ-033 Second i_drain_valid during ACTIVE -> ignored; reset_n low mid-drain -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/tt_ldb_drain_ctrl.sv
// Purpose: drains a run of LDB entries to the VRF writer as write-back beats (optional TT_LDB_DRAIN_PERF_CNT_EN adds perf counters).
// Latency: first o_wr_valid two cycles after the accepted request; one beat per cycle thereafter.
// Backpressure: i_wr_ready low holds the beat and re-reads the same LDB entry so o_wr_data stays valid.
module tt_ldb_drain_ctrl #(
  parameter int DATA_W = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_drain_valid,
  input  logic [2:0]        i_drain_ref_count,
  input  logic [2:0]        i_drain_lqid_start,
  input  logic [2:0]        i_drain_ldb_start,
  output logic              o_draining,
  output logic              o_ldb_rd_en,
  output logic [2:0]        o_ldb_rd_idx,
  input  logic [DATA_W-1:0] i_ldb_rd_data,
  output logic              o_wr_valid,
  output logic [DATA_W-1:0] o_wr_data,
  output logic [2:0]        o_wr_lqid,
  output logic              o_wr_last,
  input  logic              i_wr_ready,
  output logic              o_drain_complete_valid,
  output logic [2:0]        o_drain_complete_ldb_idx
`ifdef TT_LDB_DRAIN_PERF_CNT_EN
  ,
  output logic [31:0]       o_perf_beats,
  output logic [31:0]       o_perf_stall_cycles
`endif
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e     state_q, state_d;
  logic [2:0] remaining_q, remaining_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] lqid_ptr_q, lqid_ptr_d;
  logic       pend_vld_q, pend_vld_d;
  logic [2:0] pend_idx_q, pend_idx_d;
  logic [2:0] pend_lqid_q, pend_lqid_d;
  logic       pend_last_q, pend_last_d;
  logic       advance;

  // Beat slot moves when it is empty or the writer takes the current beat.
  assign advance = (state_q == ACTIVE) && (!pend_vld_q || i_wr_ready);

  assign o_draining               = (state_q == ACTIVE);
  assign o_wr_valid               = pend_vld_q;
  assign o_wr_data                = i_ldb_rd_data;
  assign o_wr_lqid                = pend_lqid_q;
  assign o_wr_last                = pend_last_q;
  assign o_drain_complete_valid   = pend_vld_q & i_wr_ready;
  assign o_drain_complete_ldb_idx = pend_idx_q;

  // Next-state: request capture, beat issue/hold, and exit once the final slot drains.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    rd_ptr_d     = rd_ptr_q;
    lqid_ptr_d   = lqid_ptr_q;
    pend_vld_d   = pend_vld_q;
    pend_idx_d   = pend_idx_q;
    pend_lqid_d  = pend_lqid_q;
    pend_last_d  = pend_last_q;
    o_ldb_rd_en  = 1'b0;
    o_ldb_rd_idx = pend_idx_q;
    case (state_q)
      IDLE: begin
        if (i_drain_valid) begin
          state_d     = ACTIVE;
          remaining_d = i_drain_ref_count;
          rd_ptr_d    = i_drain_ldb_start;
          lqid_ptr_d  = i_drain_lqid_start;
        end
      end
      ACTIVE: begin
        if (advance) begin
          if (remaining_q != 3'd0) begin
            o_ldb_rd_en  = 1'b1;
            o_ldb_rd_idx = rd_ptr_q;
            pend_vld_d   = 1'b1;
            pend_idx_d   = rd_ptr_q;
            pend_lqid_d  = lqid_ptr_q;
            pend_last_d  = (remaining_q == 3'd1);
            remaining_d  = remaining_q - 3'd1;
            rd_ptr_d     = rd_ptr_q + 3'd1;
            lqid_ptr_d   = lqid_ptr_q + 3'd1;
          end else begin
            // Nothing left to issue and the slot is empty after this edge.
            pend_vld_d  = 1'b0;
            pend_last_d = 1'b0;
            state_d     = IDLE;
          end
        end else begin
          // Stalled: re-read the held entry so next cycle's data still matches the beat.
          o_ldb_rd_en  = 1'b1;
          o_ldb_rd_idx = pend_idx_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and pending beat registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= 3'd0;
      rd_ptr_q    <= 3'd0;
      lqid_ptr_q  <= 3'd0;
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= 3'd0;
      pend_lqid_q <= 3'd0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rd_ptr_q    <= rd_ptr_d;
      lqid_ptr_q  <= lqid_ptr_d;
      pend_vld_q  <= pend_vld_d;
      pend_idx_q  <= pend_idx_d;
      pend_lqid_q <= pend_lqid_d;
      pend_last_q <= pend_last_d;
    end
  end

`ifdef TT_LDB_DRAIN_PERF_CNT_EN
  logic [31:0] perf_beats_q, perf_stall_q;

  // Accepted-beat and writer-stall counters; both wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_beats_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      if (pend_vld_q && i_wr_ready)  perf_beats_q <= perf_beats_q + 32'd1;
      if (pend_vld_q && !i_wr_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign o_perf_beats        = perf_beats_q;
  assign o_perf_stall_cycles = perf_stall_q;
`endif

endmodule
